// File: rtl/uabc_disp_pkg.sv
// Shared definitions for the UABC marquee display.
// Holds the active-low 7-segment glyph constants, ordered {g,f,e,d,c,b,a}.
// Also holds the display mode encoding and a small index-wrap helper.
package uabc_disp_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_SCROLL = 2'b01,
    MODE_STATIC = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  // Active-low glyphs, {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_U     = 7'b1000001;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011; // lowercase b
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_L     = 7'b1000111;
  localparam logic [6:0] GLYPH_T     = 7'b0000111; // lowercase t
  localparam logic [6:0] GLYPH_R     = 7'b0101111; // lowercase r
  localparam logic [6:0] GLYPH_O     = 7'b1000000;
  localparam logic [6:0] GLYPH_N     = 7'b0101011; // lowercase n
  localparam logic [6:0] GLYPH_I     = 7'b1111001;

  // Number of characters stored in the message ROM (index 0 is blank)
  localparam int unsigned ROM_LEN = 17;

  // Returns v+1, or 0 once v has reached last
  function automatic logic [4:0] wrap_inc(input logic [4:0] v, input logic [4:0] last);
    return (v == last) ? 5'd0 : v + 5'd1;
  endfunction

endpackage

// File: rtl/uabc_msg_rom.sv
// Combinational message ROM for the marquee.
// Holds the message blank,"UABC-ELECTRONICA" and returns the glyph for each index.
// Ports:
//   idx   : character index (5 bits); indices past the message return blank
//   glyph : active-low segment pattern {g,f,e,d,c,b,a}
module uabc_msg_rom
  import uabc_disp_pkg::*;
(
  input  logic [4:0] idx,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    unique case (idx)
      5'd0:    glyph = GLYPH_BLANK;
      5'd1:    glyph = GLYPH_U;
      5'd2:    glyph = GLYPH_A;
      5'd3:    glyph = GLYPH_B;
      5'd4:    glyph = GLYPH_C;
      5'd5:    glyph = GLYPH_DASH;
      5'd6:    glyph = GLYPH_E;
      5'd7:    glyph = GLYPH_L;
      5'd8:    glyph = GLYPH_E;
      5'd9:    glyph = GLYPH_C;
      5'd10:   glyph = GLYPH_T;
      5'd11:   glyph = GLYPH_R;
      5'd12:   glyph = GLYPH_O;
      5'd13:   glyph = GLYPH_N;
      5'd14:   glyph = GLYPH_I;
      5'd15:   glyph = GLYPH_C;
      5'd16:   glyph = GLYPH_A;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/uabc_marquee.sv
// Scrolling-message driver for a multiplexed 7-segment display.
// A prescaler produces refresh ticks, and the digit scan advances on each tick.
// A step counter, whose rate is set by speed, advances the message position in
// SCROLL mode and toggles the blank phase in BLINK mode.
// Ports:
//   clk   : clock; all state changes on the rising edge
//   rst_n : asynchronous reset, active low
//   en    : global enable; 0 behaves as mode OFF
//   mode  : 00 OFF, 01 SCROLL, 10 STATIC, 11 BLINK
//   speed : step period = (speed+1)*STEP_TICKS refresh ticks
//   seg   : active-low segments {g,f,e,d,c,b,a}, registered
//   dp    : active-low decimal point, held off
//   an    : active-low digit enables, registered, at most one low
module uabc_marquee
  import uabc_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned MSG_LEN    = 17,
  parameter int unsigned DIV_MAX    = 5000,
  parameter int unsigned STEP_TICKS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [2:0]            speed,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int unsigned PRE_W  = $clog2(DIV_MAX);
  localparam int unsigned SCAN_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W  = $clog2(8 * STEP_TICKS);

  logic [PRE_W-1:0]      presc_q;
  logic [SCAN_W-1:0]     scan_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4:0]            pos_q, pos_d;
  logic                  blank_q, blank_d;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;

  mode_e            mode_s;
  logic             off;
  logic             refresh_tick;
  logic             step;
  logic [CNT_W-1:0] thr;
  logic [4:0]       char_idx;
  logic [6:0]       glyph;

  assign mode_s       = mode_e'(mode);
  assign off          = !en || (mode_s == MODE_OFF);
  assign refresh_tick = (presc_q == PRE_W'(DIV_MAX - 1));

  // The threshold is recomputed every cycle, so a speed change applies at the
  // very next compare. ">=" lets an already-passed threshold fire on the next tick.
  assign thr  = CNT_W'((32'(speed) + 32'd1) * STEP_TICKS - 32'd1);
  assign step = refresh_tick && (cnt_q >= thr);

  // Digit NUM_DIGITS-1 is leftmost, so it shows the character at pos
  assign char_idx = 5'((32'(pos_q) + (NUM_DIGITS - 1) - 32'(scan_q)) % MSG_LEN);

  uabc_msg_rom u_rom (
    .idx   (char_idx),
    .glyph (glyph)
  );

  // Prescaler and scan run in every mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      scan_q  <= '0;
    end else begin
      presc_q <= refresh_tick ? '0 : presc_q + 1'b1;
      if (refresh_tick) begin
        scan_q <= (scan_q == SCAN_W'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;
      end
    end
  end

  // Step, position and blink-phase next state
  always_comb begin
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    blank_d = blank_q;
    if (off) begin
      cnt_d   = '0;
      pos_d   = '0;
      blank_d = 1'b0;
    end else begin
      if (refresh_tick) begin
        cnt_d = step ? '0 : cnt_q + 1'b1;
      end
      unique case (mode_s)
        MODE_SCROLL: begin
          blank_d = 1'b0;
          if (step) begin
            pos_d = wrap_inc(pos_q, 5'(MSG_LEN - 1));
          end
        end
        MODE_STATIC: begin
          pos_d   = '0;
          blank_d = 1'b0;
        end
        MODE_BLINK: begin
          if (step) begin
            blank_d = !blank_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pos_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      blank_q <= blank_d;
    end
  end

  // Outputs are registered from the current scan/pos, so they lag the refresh tick by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= GLYPH_BLANK;
      an_q  <= '1;
    end else if (off) begin
      seg_q <= GLYPH_BLANK;
      an_q  <= '1;
    end else begin
      seg_q <= glyph;
      an_q  <= blank_q ? '1 : ~(NUM_DIGITS'(1) << scan_q);
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule
